// File: rtl/move_pkg.sv
// move_pkg: shared types and constants for the move scheduler slice.
// Holds the scheduler state encoding, descriptor field width, the packed
// move descriptor and the default buffer depth exponent.
package move_pkg;

   localparam int MOVE_WORD_W         = 64;
   localparam int DEFAULT_BUFFER_BITS = 2;

   typedef enum logic [1:0] {
      MS_IDLE   = 2'd0,
      MS_LOAD   = 2'd1,
      MS_RUN    = 2'd2,
      MS_HALTED = 2'd3
   } ms_state_t;

   typedef struct packed {
      logic                   dir;
      logic [MOVE_WORD_W-1:0] duration;
      logic [MOVE_WORD_W-1:0] increment;
      logic [MOVE_WORD_W-1:0] incrementincrement;
   } move_desc_t;

endpackage

// File: rtl/move_fifo.sv
// move_fifo: circular descriptor buffer with push/pop/flush.
// The running move stays stored until it is popped, so occupancy counts it.
// Flush has priority over a push or pop issued in the same cycle.
module move_fifo
   import move_pkg::*;
#(
   parameter int BUFFER_BITS = DEFAULT_BUFFER_BITS
) (
   input  logic                 CLK,
   input  logic                 resetn,
   input  logic                 push,
   input  move_desc_t           push_data,
   input  logic                 pop,
   input  logic                 flush,
   output move_desc_t           rd_data,
   output logic [BUFFER_BITS:0] occupancy,
   output logic                 full
);

   localparam int                   DEPTH   = 1 << BUFFER_BITS;
   localparam logic [BUFFER_BITS:0] DEPTH_V = (BUFFER_BITS+1)'(DEPTH);

   move_desc_t             mem [DEPTH];
   logic [BUFFER_BITS-1:0] rd_ptr;
   logic [BUFFER_BITS-1:0] wr_ptr;

   // Descriptor storage: data only, no reset needed.
   always_ff @(posedge CLK) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush returns everything to empty.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (occupancy == DEPTH_V);

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: pops buffered move descriptors into the DDA step timer.
// IDLE -> LOAD -> RUN per segment, HALTED on halt (abort + flush).
// Optional feature macro: MOVE_SCHEDULER_STATS_EN adds the moves_completed
// and moves_aborted counters and their output ports.
module move_scheduler
   import move_pkg::*;
#(
   parameter int BUFFER_BITS = DEFAULT_BUFFER_BITS
) (
   input  logic                          CLK,
   input  logic                          resetn,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic                          wr_dir,
   input  logic [MOVE_WORD_W-1:0]        wr_duration,
   input  logic signed [MOVE_WORD_W-1:0] wr_increment,
   input  logic signed [MOVE_WORD_W-1:0] wr_incrementincrement,
   input  logic                          halt,
   output logic                          move_dir,
   output logic [MOVE_WORD_W-1:0]        move_duration,
   output logic signed [MOVE_WORD_W-1:0] move_increment,
   output logic signed [MOVE_WORD_W-1:0] move_incrementincrement,
   output logic                          move_start,
   output logic                          move_abort,
   input  logic                          move_done,
   output logic                          busy,
   output logic [BUFFER_BITS:0]          occupancy,
   output logic                          buffer_dtr
`ifdef MOVE_SCHEDULER_STATS_EN
   ,
   output logic [31:0]                   moves_completed,
   output logic [15:0]                   moves_aborted
`endif
);

   localparam int                   DEPTH     = 1 << BUFFER_BITS;
   localparam logic [BUFFER_BITS:0] DTR_LIMIT = (BUFFER_BITS+1)'(DEPTH - 1);
   localparam logic [BUFFER_BITS:0] OCC_ONE   = (BUFFER_BITS+1)'(1);

   ms_state_t  state;
   ms_state_t  state_next;
   move_desc_t wr_desc;
   move_desc_t rd_desc;
   logic       fifo_full;
   logic       push;
   logic       do_pop;
   logic       do_load;
   logic       flush;
   logic       halt_entry;

   assign wr_desc.dir                = wr_dir;
   assign wr_desc.duration           = wr_duration;
   assign wr_desc.increment          = wr_increment;
   assign wr_desc.incrementincrement = wr_incrementincrement;

   assign wr_ready   = !fifo_full && (state != MS_HALTED);
   assign push       = wr_valid && wr_ready;
   assign busy       = (state == MS_LOAD) || (state == MS_RUN);
   assign buffer_dtr = (occupancy < DTR_LIMIT);
   assign halt_entry = (state_next == MS_HALTED) && (state != MS_HALTED);

   move_fifo #(
      .BUFFER_BITS (BUFFER_BITS)
   ) u_fifo (
      .CLK       (CLK),
      .resetn    (resetn),
      .push      (push),
      .push_data (wr_desc),
      .pop       (do_pop),
      .flush     (flush),
      .rd_data   (rd_desc),
      .occupancy (occupancy),
      .full      (fifo_full)
   );

   // State register.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state <= MS_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; halt overrides everything, including a same-cycle done.
   always_comb begin
      state_next = state;
      do_pop     = 1'b0;
      do_load    = 1'b0;
      case (state)
         MS_IDLE: begin
            if (halt) begin
               state_next = MS_HALTED;
            end else if (occupancy != '0) begin
               state_next = MS_LOAD;
            end
         end
         MS_LOAD: begin
            if (halt) begin
               state_next = MS_HALTED;
            end else begin
               do_load    = 1'b1;
               state_next = MS_RUN;
            end
         end
         MS_RUN: begin
            if (halt) begin
               state_next = MS_HALTED;
            end else if (move_done) begin
               do_pop = 1'b1;
               // Occupancy after the pop, counting a simultaneous push.
               if ((occupancy > OCC_ONE) || push) begin
                  state_next = MS_LOAD;
               end else begin
                  state_next = MS_IDLE;
               end
            end
         end
         MS_HALTED: begin
            if (!halt) begin
               state_next = MS_IDLE;
            end
         end
         default: state_next = MS_IDLE;
      endcase
      flush = (state_next == MS_HALTED);
   end

   // Move descriptor and start/abort pulses toward the DDA.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         move_dir                <= 1'b0;
         move_duration           <= '0;
         move_increment          <= '0;
         move_incrementincrement <= '0;
         move_start              <= 1'b0;
         move_abort              <= 1'b0;
      end else begin
         move_start <= do_load;
         move_abort <= halt_entry;
         if (do_load) begin
            move_dir                <= rd_desc.dir;
            move_duration           <= rd_desc.duration;
            move_increment          <= $signed(rd_desc.increment);
            move_incrementincrement <= $signed(rd_desc.incrementincrement);
         end
      end
   end

`ifdef MOVE_SCHEDULER_STATS_EN
   // Completed-move counter (wrapping) and abort counter (saturating).
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         moves_completed <= '0;
         moves_aborted   <= '0;
      end else begin
         if (do_pop) begin
            moves_completed <= moves_completed + 1'b1;
         end
         if (halt_entry && ((state == MS_RUN) || (state == MS_LOAD)) &&
             (moves_aborted != 16'hFFFF)) begin
            moves_aborted <= moves_aborted + 1'b1;
         end
      end
   end
`endif

endmodule
